// File: rtl/phoenix_input_buffer.sv
// Phoenix router input port: circular flit FIFO with credit flow control,
// packet-framing FSM and XY route request toward the switch control.
module phoenix_input_buffer #(
    parameter int unsigned TAM_FLIT   = 16,
    parameter int unsigned BUFF_DEPTH = 16,
    parameter int unsigned ADDR_X     = 0,
    parameter int unsigned ADDR_Y     = 0,
    localparam int unsigned PTR_W     = $clog2(BUFF_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    output logic [2:0]          route,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                data_ack,
    output logic                sender,
    output logic [PTR_W:0]      count
);

    localparam int unsigned       HALF = TAM_FLIT / 2;
    localparam logic [HALF-1:0]   MY_X = HALF'(ADDR_X);
    localparam logic [HALF-1:0]   MY_Y = HALF'(ADDR_Y);
    localparam logic [PTR_W:0]    FULL = (PTR_W + 1)'(BUFF_DEPTH);

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    state_t              state_q, state_d;
    logic [TAM_FLIT-1:0] mem_q [BUFF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [TAM_FLIT-1:0] flit_cnt_q, flit_cnt_d;
    logic [2:0]          route_q, route_d;

    logic wr_en;
    logic rd_en;
    logic not_empty;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [2:0] xyRoute(input logic [TAM_FLIT-1:0] hdr);
        logic [HALF-1:0] dx;
        logic [HALF-1:0] dy;
        logic [2:0]      dir;
        dx = hdr[TAM_FLIT-1:HALF];
        dy = hdr[HALF-1:0];
        if (dx > MY_X)      dir = EAST;
        else if (dx < MY_X) dir = WEST;
        else if (dy > MY_Y) dir = NORTH;
        else if (dy < MY_Y) dir = SOUTH;
        else                dir = LOCAL;
        return dir;
    endfunction

    assign not_empty = (count_q != '0);
    assign credit_o  = reset & (count_q != FULL);
    assign wr_en     = rx & credit_o;
    assign rd_en     = data_av & data_ack;
    assign data_out  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign route     = route_q;

    // The header flit always reaches the head before S_HDR, so it needs no occupancy check.
    assign h       = reset & (state_q == S_REQ);
    assign sender  = reset & ((state_q == S_HDR) | (state_q == S_SIZE) | (state_q == S_PAYLOAD));
    assign data_av = reset & ((state_q == S_HDR) |
                              (((state_q == S_SIZE) | (state_q == S_PAYLOAD)) & not_empty));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        flit_cnt_d = flit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (not_empty) begin
                    route_d = xyRoute(data_out);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_h) state_d = S_HDR;
            end
            S_HDR: begin
                if (rd_en) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (rd_en) begin
                    flit_cnt_d = data_out;
                    state_d    = (data_out == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rd_en) begin
                    flit_cnt_d = flit_cnt_q - TAM_FLIT'(1);
                    if (flit_cnt_q == TAM_FLIT'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flit_cnt_q <= '0;
            route_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flit_cnt_q <= flit_cnt_d;
            route_q    <= route_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_phoenix_input_buffer.sv
// Directed self-checking bench for phoenix_input_buffer at router (1,1)
// with a 4-flit buffer.
module tb_phoenix_input_buffer;

    localparam int TAM_FLIT   = 16;
    localparam int BUFF_DEPTH = 4;
    localparam int PTR_W      = 2;

    logic                clock;
    logic                reset;
    logic                rx;
    logic [TAM_FLIT-1:0] dataIn;
    logic                creditO;
    logic                h;
    logic [2:0]          route;
    logic                ackH;
    logic                dataAv;
    logic [TAM_FLIT-1:0] dataOut;
    logic                dataAck;
    logic                sender;
    logic [PTR_W:0]      count;

    int checks = 0;
    int errors = 0;

    phoenix_input_buffer #(
        .TAM_FLIT  (TAM_FLIT),
        .BUFF_DEPTH(BUFF_DEPTH),
        .ADDR_X    (1),
        .ADDR_Y    (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .data_in (dataIn),
        .credit_o(creditO),
        .h       (h),
        .route   (route),
        .ack_h   (ackH),
        .data_av (dataAv),
        .data_out(dataOut),
        .data_ack(dataAck),
        .sender  (sender),
        .count   (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rxV, input logic [15:0] dataV, input logic ackHV, input logic dataAckV);
        rx      = rxV;
        dataIn  = dataV;
        ackH    = ackHV;
        dataAck = dataAckV;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushFlit(input logic [15:0] flit);
        applyStimulus(1'b1, flit, h, 1'b0);
        tick();
    endtask

    logic [15:0] hdr3 [4];
    logic [2:0]  rt3  [4];
    logic [15:0] pkt4 [6];
    logic [15:0] pay4 [3];
    logic [15:0] pkt5 [10];
    logic [2:0]  routeSeen [2];
    int          sent, recv, hRises, recvAtSecondH, extraReads;
    logic        hPrev;

    initial begin
        // Test 1: reset held low with traffic offered
        reset = 1'b0;
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("t1_credit_in_reset", creditO, 0);
        checkOutput("t1_h_in_reset", h, 0);
        checkOutput("t1_av_in_reset", dataAv, 0);
        checkOutput("t1_sender_in_reset", sender, 0);
        checkOutput("t1_count_in_reset", count, 0);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        checkOutput("t1_credit_after_release", creditO, 1);
        tick();
        checkOutput("t1_count_after_release", count, 0);
        checkOutput("t1_av_after_release", dataAv, 0);

        // Test 2: one packet, header east of (1,1), two payload flits
        applyStimulus(1'b1, 16'h0201, 1'b0, 1'b1);
        tick();
        checkOutput("t2_h_after_E", h, 0);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b1);
        tick();
        checkOutput("t2_h_after_E1", h, 1);
        checkOutput("t2_route", route, 0);
        applyStimulus(1'b1, 16'hAAAA, 1'b1, 1'b1);
        tick();
        checkOutput("t2_av_after_ack", dataAv, 1);
        checkOutput("t2_sender_after_ack", sender, 1);
        checkOutput("t2_head", dataOut, 16'h0201);
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b1);
        tick();
        checkOutput("t2_count_wr_rd", count, 3);
        checkOutput("t2_size", dataOut, 16'h0002);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("t2_pay0", dataOut, 16'hAAAA);
        tick();
        checkOutput("t2_pay1", dataOut, 16'hBBBB);
        checkOutput("t2_sender_last", sender, 1);
        tick();
        checkOutput("t2_sender_end", sender, 0);
        checkOutput("t2_av_end", dataAv, 0);
        checkOutput("t2_count_end", count, 0);

        // Test 3: each non-east direction with zero-size packets
        hdr3 = '{16'h0001, 16'h0102, 16'h0100, 16'h0101};
        rt3  = '{3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, hdr3[i], 1'b0, 1'b1);
            tick();
            applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("t3_h_%0d", i), h, 1);
            checkOutput($sformatf("t3_route_%0d", i), route, rt3[i]);
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
            tick();
            checkOutput($sformatf("t3_hdr_%0d", i), dataOut, hdr3[i]);
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("t3_size_av_%0d", i), dataAv, 1);
            checkOutput($sformatf("t3_size_%0d", i), dataOut, 0);
            tick();
            checkOutput($sformatf("t3_sender_end_%0d", i), sender, 0);
            checkOutput($sformatf("t3_count_end_%0d", i), count, 0);
        end

        // Test 4: fill to full, overflow flits dropped, then read and simultaneous rx+read
        pkt4 = '{16'h0101, 16'h0003, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, pkt4[i], 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("t4_count_%0d", i), count, (i < 3) ? i + 1 : 4);
            checkOutput($sformatf("t4_credit_%0d", i), creditO, (i < 3) ? 1 : 0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("t4_credit_full_hdr", creditO, 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("t4_count_after_read", count, 3);
        checkOutput("t4_credit_after_read", creditO, 1);
        applyStimulus(1'b1, 16'hC003, 1'b0, 1'b1);
        tick();
        checkOutput("t4_count_rx_and_read", count, 3);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        pay4 = '{16'hC001, 16'hC002, 16'hC003};
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t4_pay_%0d", i), dataOut, pay4[i]);
            tick();
        end
        checkOutput("t4_sender_end", sender, 0);
        checkOutput("t4_count_end", count, 0);

        // Test 5: two back-to-back size-3 packets with random downstream stalls
        pkt5 = '{16'h0101, 16'h0003, 16'hD001, 16'hD002, 16'hD003,
                 16'h0001, 16'h0003, 16'hE001, 16'hE002, 16'hE003};
        sent = 0; recv = 0; hRises = 0; recvAtSecondH = -1; extraReads = 0;
        hPrev = 1'b0;
        routeSeen = '{3'd7, 3'd7};
        for (int cyc = 0; cyc < 400 && !(recv == 10 && !sender && count == 0); cyc++) begin
            if (h && !hPrev) begin
                if (hRises < 2) routeSeen[hRises] = route;
                if (hRises == 1) recvAtSecondH = recv;
                hRises++;
            end
            hPrev = h;
            applyStimulus((sent < 10) && creditO, pkt5[(sent < 10) ? sent : 9], h, 1'($urandom_range(0, 1)));
            if (dataAv && dataAck) begin
                if (recv < 10) checkOutput($sformatf("t5_flit_%0d", recv), dataOut, pkt5[recv]);
                else extraReads++;
                recv++;
            end
            if (rx && creditO) sent++;
            tick();
        end
        checkOutput("t5_sent", sent, 10);
        checkOutput("t5_received", recv, 10);
        checkOutput("t5_extra_reads", extraReads, 0);
        checkOutput("t5_h_rises", hRises, 2);
        checkOutput("t5_recv_at_second_h", recvAtSecondH, 5);
        checkOutput("t5_route0", routeSeen[0], 4);
        checkOutput("t5_route1", routeSeen[1], 1);
        checkOutput("t5_count_end", count, 0);

        // Test 6: reset in the middle of a payload, then a fresh packet
        pushFlit(16'h0101);
        pushFlit(16'h0003);
        pushFlit(16'hF001);
        pushFlit(16'hF002);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (2) tick();
        checkOutput("t6_sender_payload", sender, 1);
        checkOutput("t6_count_payload", count, 2);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checkOutput("t6_count_reset", count, 0);
        checkOutput("t6_sender_reset", sender, 0);
        checkOutput("t6_av_reset", dataAv, 0);
        checkOutput("t6_credit_reset", creditO, 0);
        reset = 1'b1;
        tick();
        checkOutput("t6_count_idle", count, 0);
        applyStimulus(1'b1, 16'h0201, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("t6_h_fresh", h, 1);
        checkOutput("t6_route_fresh", route, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        checkOutput("t6_hdr_fresh", dataOut, 16'h0201);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (2) tick();
        checkOutput("t6_sender_end", sender, 0);
        checkOutput("t6_count_end", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
